// File: rtl/sgemv_issuer.sv
// Host-side job issuer for the sgemv engine: stages A rows/B/C, emits 4 A beats one cycle after start,
// captures the engine result, and holds it on res_valid until res_ready; aborts after TIMEOUT wait cycles.
module sgemv_issuer #(
    parameter int DATA_W  = 128,
    parameter int TIMEOUT = 16
) (
    input  logic              ref_clk,
    input  logic              rst_n,
    input  logic              cfg_wr_en,
    input  logic [2:0]        cfg_wr_addr,
    input  logic [DATA_W-1:0] cfg_wr_data,
    input  logic              start,
    output logic              busy,
    output logic [DATA_W-1:0] A_in,
    output logic              A_valid,
    output logic [DATA_W-1:0] B_in,
    output logic              B_valid,
    output logic [DATA_W-1:0] C_in,
    output logic              C_valid,
    input  logic [DATA_W-1:0] sgemv_out,
    input  logic              sgemv_out_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_A   = 2'd1,
        WAIT_RES = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic [7:0]        wait_q, wait_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              terr_q, terr_d;

    logic [DATA_W-1:0] row_q [4];
    logic [DATA_W-1:0] b_q, c_q;

    logic              send_a;
    logic              first_beat;

    // Staging is only writable while idle so a running job always sees a consistent snapshot.
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) row_q[i] <= '0;
            b_q <= '0;
            c_q <= '0;
        end else if (cfg_wr_en && state_q == IDLE) begin
            case (cfg_wr_addr)
                3'd0, 3'd1, 3'd2, 3'd3: row_q[cfg_wr_addr[1:0]] <= cfg_wr_data;
                3'd4:                   b_q <= cfg_wr_data;
                3'd5:                   c_q <= cfg_wr_data;
                default:                ;
            endcase
        end
    end

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            wait_q  <= '0;
            res_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            res_q   <= res_d;
            terr_q  <= terr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        res_d   = res_q;
        terr_d  = terr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEND_A;
                    beat_d  = '0;
                    terr_d  = 1'b0;
                end
            end
            SEND_A: begin
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = WAIT_RES;
                    wait_d  = '0;
                end
            end
            WAIT_RES: begin
                wait_d = wait_q + 8'd1;
                if (sgemv_out_valid) begin
                    res_d   = sgemv_out;
                    state_d = DONE;
                end else if (wait_q == WAIT_LAST) begin
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat outputs decode straight from state so an async reset silences them immediately.
    assign send_a      = (state_q == SEND_A);
    assign first_beat  = send_a && (beat_q == 2'd0);

    assign busy        = (state_q != IDLE);
    assign A_valid     = send_a;
    assign A_in        = send_a ? row_q[beat_q] : '0;
    assign B_valid     = first_beat;
    assign B_in        = first_beat ? b_q : '0;
    assign C_valid     = first_beat;
    assign C_in        = first_beat ? c_q : '0;
    assign res_valid   = (state_q == DONE);
    assign res_data    = res_q;
    assign timeout_err = terr_q;

endmodule

// File: doc/sgemv_issuer.md
Name: sgemv_issuer

Overview:
- Upstream transmitter for the sgemv engine.
- A host loads one job (4 A rows, vector B, vector C) into local staging registers, then pulses start.
- The block drives the sgemv beat protocol (four A beats; B and C on the first beat) and waits for the engine's out/out_valid.
- It returns the result word to the host over a valid/ready handshake, with a timeout if the engine never answers.

Parameters:
- DATA_W, 128, width of every beat and of the result word (4 lanes x 32 bit; lane k = bits [32k+31:32k]).
- TIMEOUT, 16, maximum cycles spent in WAIT_RES before the job is aborted; legal range 4..255.

Ports:
- ref_clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_wr_en  in  1  staging write strobe.
- cfg_wr_addr  in  3  0-3 = A row 0-3, 4 = B, 5 = C, 6-7 = ignored.
- cfg_wr_data  in  DATA_W  staging write data.
- start  in  1  single-cycle job start; honoured only in IDLE.
- busy  out  1  high whenever state != IDLE.
- A_in  out  DATA_W  A row beat to the engine.
- A_valid  out  1  A beat qualifier.
- B_in  out  DATA_W  B vector to the engine.
- B_valid  out  1  B qualifier.
- C_in  out  DATA_W  C vector to the engine.
- C_valid  out  1  C qualifier.
- sgemv_out  in  DATA_W  engine result word.
- sgemv_out_valid  in  1  engine result qualifier.
- res_data  out  DATA_W  captured result.
- res_valid  out  1  result available.
- res_ready  in  1  host accepts the result.
- timeout_err  out  1  sticky flag; set on timeout, cleared by the next accepted start.

Behaviour:
- Reset: when rst_n is low, the state is forced to IDLE at once and all staging registers, outputs and counters go to 0. A reset mid-job abandons the job and emits no further beats. Engine-side residual state is the host's concern; the bench resets both together.
- Staging writes are accepted only in IDLE. In any other state they are ignored and the staging contents are unchanged. A write in the same cycle as an accepted start commits at that edge and is included in the job.
- FSM:
  - IDLE -> SEND_A when start=1. timeout_err clears on this edge.
  - SEND_A lasts exactly 4 cycles, beat counter 0..3.
    - A_valid=1 and A_in=row[beat] in each of the 4 cycles.
    - B_valid=C_valid=1 with B_in/C_in = staged B/C on beat 0 only.
    - After beat 3 -> WAIT_RES.
    - The block never emits fewer than 4 A beats, because the engine's row counter only wraps after 4 beats.
  - WAIT_RES: the wait counter starts at 0 and increments each cycle.
    - sgemv_out_valid=1: res_data <= sgemv_out -> DONE.
    - Otherwise, counter == TIMEOUT-1: timeout_err <= 1 -> IDLE, no result.
  - DONE: res_valid=1 and res_data held stable until res_ready=1. Transfer on res_valid&&res_ready -> IDLE; res_valid drops at that edge.
- Latency: start sampled at edge T.
  - A beats occupy cycles T+1..T+4.
  - The engine answers in cycle T+6.
  - res_valid rises in cycle T+7.
  - busy is high from T+1 until the cycle after the handshake.
- Outside SEND_A: A_valid, B_valid and C_valid are 0, and A_in, B_in, C_in are driven 0.
- sgemv_out_valid outside WAIT_RES is ignored.
- start outside IDLE, including in DONE, is ignored. Starts do not queue.
- res_ready outside DONE has no effect.
- No arithmetic is performed: res_data is a bit-exact copy of sgemv_out.

Test Plan:
- Reset, then load rows 0-3 with 128'h...1/2/3/4 patterns, B = 128'hAA.., C = 128'hCC..; pulse start at T -> A_valid high T+1..T+4 with rows 0,1,2,3 in order; B_valid/C_valid high only at T+1 with the staged values; busy rises at T+1.
- Engine stub returns 128'h0000000E_0000000B_00000008_00000005 in WAIT_RES with res_ready held 1 -> res_valid one cycle later, res_data equal to that word, busy low the following cycle.
- Hold res_ready=0 for 5 cycles in DONE, toggle sgemv_out to a new word, pulse start -> res_data unchanged, no new A beats; release res_ready -> single transfer.
- Stub never asserts out_valid, TIMEOUT=16 -> timeout_err=1 after 16 WAIT_RES cycles, state IDLE, res_valid never asserted; the next start clears timeout_err.
- In IDLE, cfg_wr_en to row 2 in the same cycle as start -> beat 2 carries the new data. A write to B during SEND_A is ignored; the next job sends the old B.
- Assert rst_n=0 mid-SEND_A (after beat 1) -> A_valid and busy drop immediately. After release there are no beats until a new start, and staging reads back as 0.
